// File: rtl/marquee_ctrl.sv
// marquee_ctrl: rotating-digit marquee sequencer.
// Scrolls a loaded N-bit pattern one WIDTH-bit digit per tick in either
// direction, with pause/resume/abort control and an optional single-revolution mode.
module marquee_ctrl #(
    parameter int N     = 32,
    parameter int WIDTH = 4,
    localparam int DIGITS = N / WIDTH,
    localparam int PW     = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int CW     = PW + 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          tick,
    input  logic          start,
    input  logic          stop,
    input  logic          dir_in,
    input  logic          oneshot_in,
    input  logic          ld_valid,
    input  logic [N-1:0]  ld_data,
    output logic          ld_ready,
    output logic [N-1:0]  seq_out,
    output logic [PW-1:0] pos,
    output logic          step,
    output logic          dir,
    output logic [1:0]    state,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pattern_q;
    logic [CW-1:0] cnt_q;
    logic          oneshot_q;

    logic          do_load, do_start, do_rot, do_clear;
    logic          last_step;
    logic [N-1:0]  rot_r, rot_l, rot_nx;
    logic [PW-1:0] pos_nx;

    assign state    = state_q;
    assign ld_ready = (state_q == IDLE) || (state_q == DONE);

    // The step that completes a full revolution is the DIGITS-th one.
    assign last_step = (cnt_q == CW'(DIGITS - 1));

    assign rot_r  = {seq_out[WIDTH-1:0], seq_out[N-1:WIDTH]};
    assign rot_l  = {seq_out[N-WIDTH-1:0], seq_out[N-1:N-WIDTH]};
    assign rot_nx = dir ? rot_r : rot_l;

    // Offset wraps explicitly so non-power-of-two digit counts also work.
    assign pos_nx = dir ? ((pos == PW'(DIGITS - 1)) ? '0 : pos + PW'(1))
                        : ((pos == '0) ? PW'(DIGITS - 1) : pos - PW'(1));

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and datapath commands; stop outranks start everywhere,
    // and a load outranks any command while the pattern is writable.
    always_comb begin
        state_d  = state_q;
        do_load  = 1'b0;
        do_start = 1'b0;
        do_rot   = 1'b0;
        do_clear = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (ld_valid) begin
                    do_load = 1'b1;
                    state_d = IDLE;
                end else if (start && !stop) begin
                    do_start = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    do_rot = 1'b1;
                    if (oneshot_q && last_step) state_d = DONE;
                end
            end
            PAUSE: begin
                if (stop) begin
                    do_clear = 1'b1;
                    state_d  = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pattern, rotation offset, step counter and the registered pulses.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pattern_q <= '0;
            seq_out   <= '0;
            pos       <= '0;
            cnt_q     <= '0;
            dir       <= 1'b0;
            oneshot_q <= 1'b0;
            step      <= 1'b0;
            done      <= 1'b0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            if (do_load) begin
                pattern_q <= ld_data;
                seq_out   <= ld_data;
                pos       <= '0;
                cnt_q     <= '0;
            end
            if (do_start) begin
                dir       <= dir_in;
                oneshot_q <= oneshot_in;
                cnt_q     <= '0;
            end
            if (do_rot) begin
                seq_out <= rot_nx;
                pos     <= pos_nx;
                step    <= 1'b1;
                cnt_q   <= last_step ? '0 : cnt_q + CW'(1);
                done    <= oneshot_q && last_step;
            end
            if (do_clear) begin
                seq_out <= pattern_q;
                pos     <= '0;
                cnt_q   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_marquee_ctrl.sv
// Scoreboard bench for marquee_ctrl: each issued tick pushes the expected
// post-rotation view; a monitor pops and compares whenever step pulses.
module tb_marquee_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst, tick, start, stop, dir_in, oneshot_in, ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready, step, dir, done;
    logic [31:0] seq_out;
    logic [2:0]  pos;
    logic [1:0]  state;

    typedef struct {
        logic [31:0] seq;
        logic [2:0]  pos;
        logic        done;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    marquee_ctrl #(.N(32), .WIDTH(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tick(tick), .start(start),
        .stop(stop), .dir_in(dir_in), .oneshot_in(oneshot_in),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .seq_out(seq_out), .pos(pos), .step(step), .dir(dir),
        .state(state), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every step pulse must match the oldest outstanding expectation.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (step) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_step: got step=1 expected no step (pos=%0d)", pos);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_seq",   seq_out,        e.seq);
                    chk("sb_pos",   32'(pos),       32'(e.pos));
                    chk("sb_done",  32'(done),      32'(e.done));
                    chk("sb_state", 32'(state),     32'(e.st));
                end
            end else if (done) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_without_step: got done=1 expected 0");
            end
        end
    end

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic tick_exp(input logic [31:0] s, input logic [2:0] p,
                            input logic d, input logic [1:0] st);
        exp_t e;
        e.seq = s; e.pos = p; e.done = d; e.st = st;
        exp_q.push_back(e);
        tick = 1'b1; cyc(); tick = 1'b0; cyc();
    endtask

    task automatic tick_none();
        tick = 1'b1; cyc(); tick = 1'b0; cyc();
    endtask

    task automatic load(input logic [31:0] d);
        ld_valid = 1'b1; ld_data = d; cyc(); ld_valid = 1'b0;
    endtask

    task automatic cmd_start(input logic d, input logic o);
        dir_in = d; oneshot_in = o; start = 1'b1; cyc();
        start = 1'b0; dir_in = ~d; oneshot_in = ~o;   // later changes must not matter
    endtask

    task automatic cmd_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1; tick = 0; start = 0; stop = 0; dir_in = 0;
        oneshot_in = 0; ld_valid = 0; ld_data = '0;
        cyc(); cyc();
        chk("rst_state",    32'(state),    32'd0);
        chk("rst_seq",      seq_out,       32'h0);
        chk("rst_pos",      32'(pos),      32'd0);
        chk("rst_dir",      32'(dir),      32'd0);
        chk("rst_step",     32'(step),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        sys_rst = 1'b0;
        cyc();

        // Continuous rotate right.
        load(32'h12345678);
        chk("load_seq", seq_out, 32'h12345678);
        cmd_start(1'b1, 1'b0);
        chk("run_state", 32'(state), 32'd1);
        chk("run_dir",   32'(dir),   32'd1);
        chk("run_ld_ready", 32'(ld_ready), 32'd0);
        tick_exp(32'h81234567, 3'd1, 1'b0, 2'd1);
        tick_exp(32'h78123456, 3'd2, 1'b0, 2'd1);
        tick_exp(32'h67812345, 3'd3, 1'b0, 2'd1);

        // Pause then abort restores the pattern.
        cmd_stop();
        chk("pause_state", 32'(state), 32'd2);
        cmd_stop();
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_seq",   seq_out,    32'h12345678);
        chk("abort_pos",   32'(pos),   32'd0);
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk("idle_startstop_state", 32'(state), 32'd0);

        // Stop with coincident tick, pause ignores ticks, resume keeps dir.
        cmd_start(1'b1, 1'b0);
        tick_exp(32'h81234567, 3'd1, 1'b0, 2'd1);
        tick_exp(32'h78123456, 3'd2, 1'b0, 2'd1);
        stop = 1'b1; tick = 1'b1; cyc(); stop = 1'b0; tick = 1'b0; cyc();
        chk("stoptick_state", 32'(state), 32'd2);
        chk("stoptick_pos",   32'(pos),   32'd2);
        chk("stoptick_seq",   seq_out,    32'h78123456);
        tick_none();
        chk("pause_tick_pos", 32'(pos), 32'd2);
        cmd_start(1'b0, 1'b1);
        chk("resume_state", 32'(state), 32'd1);
        chk("resume_dir",   32'(dir),   32'd1);
        tick_exp(32'h67812345, 3'd3, 1'b0, 2'd1);
        cmd_stop();
        cmd_stop();
        chk("idle2_seq", seq_out, 32'h12345678);

        // One-shot rotate left; load held during RUN must be refused.
        cmd_start(1'b0, 1'b1);
        chk("os_dir", 32'(dir), 32'd0);
        ld_valid = 1'b1; ld_data = 32'hDEADBEEF;
        tick_exp(32'h23456781, 3'd7, 1'b0, 2'd1);
        chk("run_load_refused", 32'(ld_ready), 32'd0);
        tick_exp(32'h34567812, 3'd6, 1'b0, 2'd1);
        tick_exp(32'h45678123, 3'd5, 1'b0, 2'd1);
        tick_exp(32'h56781234, 3'd4, 1'b0, 2'd1);
        tick_exp(32'h67812345, 3'd3, 1'b0, 2'd1);
        tick_exp(32'h78123456, 3'd2, 1'b0, 2'd1);
        tick_exp(32'h81234567, 3'd1, 1'b0, 2'd1);
        ld_valid = 1'b0;
        tick_exp(32'h12345678, 3'd0, 1'b1, 2'd3);
        chk("done_state", 32'(state), 32'd3);
        chk("done_pulse_over", 32'(done), 32'd0);
        tick_none();
        chk("done_hold_seq", seq_out,  32'h12345678);
        chk("done_hold_pos", 32'(pos), 32'd0);
        load(32'hA5A5A5A5);
        chk("done_load_seq",   seq_out,    32'hA5A5A5A5);
        chk("done_load_state", 32'(state), 32'd0);

        // Reset mid-RUN overrides everything.
        cmd_start(1'b1, 1'b0);
        tick_exp(32'h5A5A5A5A, 3'd1, 1'b0, 2'd1);
        tick_exp(32'hA5A5A5A5, 3'd2, 1'b0, 2'd1);
        tick_exp(32'h5A5A5A5A, 3'd3, 1'b0, 2'd1);
        tick_exp(32'hA5A5A5A5, 3'd4, 1'b0, 2'd1);
        tick_exp(32'h5A5A5A5A, 3'd5, 1'b0, 2'd1);
        sys_rst = 1'b1; tick = 1'b1; ld_valid = 1'b1; ld_data = 32'h0F0F0F0F; start = 1'b1;
        cyc();
        sys_rst = 1'b0; tick = 1'b0; ld_valid = 1'b0; start = 1'b0;
        chk("mrst_state",    32'(state),    32'd0);
        chk("mrst_seq",      seq_out,       32'h0);
        chk("mrst_pos",      32'(pos),      32'd0);
        chk("mrst_dir",      32'(dir),      32'd0);
        chk("mrst_step",     32'(step),     32'd0);
        chk("mrst_done",     32'(done),     32'd0);
        chk("mrst_ld_ready", 32'(ld_ready), 32'd1);

        cyc(); cyc();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/marquee_ctrl.md
MARQUEE_CTRL -- requirements
Module: marquee_ctrl

Interface
REQ-001 Parameter N, default 32: pattern width in bits.
REQ-002 Parameter WIDTH, default 4: bits per display digit; DIGITS = N/WIDTH (default 8), N SHALL be a multiple of WIDTH.
REQ-003 sys_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 sys_rst  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  one-cycle step strobe from the slow divider domain, already synchronous to sys_clk.
REQ-006 start  input  1  one-cycle command pulse: begin or resume scrolling.
REQ-007 stop  input  1  one-cycle command pulse: pause, or abort when already paused.
REQ-008 dir_in  input  1  requested direction, 1 = rotate right, 0 = rotate left.
REQ-009 oneshot_in  input  1  1 = stop after one full revolution, 0 = scroll forever.
REQ-010 ld_valid  input  1  load request; ld_data valid while high.
REQ-011 ld_data  input  N  new pattern.
REQ-012 ld_ready  output  1  high when a load is accepted this cycle.
REQ-013 seq_out  output  N  current rotated pattern driven to the digit decoder.
REQ-014 pos  output  clog2(DIGITS)  current rotation offset in digits.
REQ-015 step  output  1  one-cycle pulse on every applied rotation.
REQ-016 dir  output  1  latched direction in use.
REQ-017 state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-018 done  output  1  one-cycle pulse on entry to DONE.

Function
REQ-019 FSM SHALL have exactly states IDLE, RUN, PAUSE, DONE.
REQ-020 ld_ready SHALL equal (state==IDLE || state==DONE), combinationally from state.
REQ-021 Load accepted (ld_valid && ld_ready): pattern <= ld_data, seq_out <= ld_data, pos <= 0, step count <= 0, state <= IDLE; visible next cycle.
REQ-022 IDLE/DONE + start (no load, no stop same cycle): dir <= dir_in, oneshot latch <= oneshot_in, step count <= 0, state <= RUN.
REQ-023 Load and start in the same cycle: load applies, start ignored, state IDLE.
REQ-024 RUN + tick (no stop): rotate seq_out by WIDTH bits (right if dir=1, left if dir=0), pos <= pos+1 mod DIGITS (dir=1) or pos-1 mod DIGITS (dir=0), step high the following cycle, step count +1; latency tick -> updated seq_out/pos = 1 cycle.
REQ-025 RUN, oneshot latched, tick producing the DIGITS-th step: state <= DONE and done high in the same cycle as step; seq_out then equals pattern, pos = 0.
REQ-026 RUN + stop: state <= PAUSE; a coincident tick SHALL NOT rotate.
REQ-027 PAUSE: ticks ignored; seq_out, pos, dir, step count held.
REQ-028 PAUSE + start: state <= RUN, dir and oneshot latch retained (dir_in not resampled).
REQ-029 PAUSE + stop: state <= IDLE, seq_out <= pattern, pos <= 0, step count <= 0.
REQ-030 start and stop in the same cycle: stop wins in every state; in IDLE/DONE stop alone is a no-op.
REQ-031 dir_in, oneshot_in changes outside REQ-022 SHALL have no effect.
REQ-032 start in RUN SHALL be ignored.
REQ-033 Step count width clog2(DIGITS)+1; SHALL not overflow in continuous mode (wraps to 0 at DIGITS).

Reset
REQ-034 sys_rst high at an edge: state=IDLE, pattern=0, seq_out=0, pos=0, step count=0, dir=0, oneshot latch=0, step=0, done=0; ld_ready=1 in the following cycle.
REQ-035 Reset SHALL override every other input in the same cycle, including mid-RUN and mid-load.

Verification
REQ-036 Load 0x12345678, start with dir_in=1, oneshot_in=0, 3 ticks -> seq_out 0x81234567, 0x78123456, 0x67812345; pos 1,2,3; three step pulses.
REQ-037 Load 0x12345678, start dir_in=0, oneshot_in=1, 8 ticks -> seq_out 0x23456781 after first tick; after 8th: seq_out 0x12345678, pos 0, state DONE, done one cycle; 9th tick no change.
REQ-038 RUN with pos=2, stop and tick same cycle -> state PAUSE, pos stays 2; further ticks ignored; start -> RUN, next tick pos 3.
REQ-039 PAUSE, stop -> state IDLE, seq_out = loaded pattern, pos 0; start+stop same cycle in IDLE -> stays IDLE.
REQ-040 ld_valid held high during RUN -> ld_ready 0, pattern unchanged; after oneshot reaches DONE, load 0xA5A5A5A5 accepted next cycle, state IDLE.
REQ-041 sys_rst asserted mid-RUN at pos 5 -> next cycle state IDLE, seq_out 0, pos 0, dir 0, step/done 0, ld_ready 1.
